// File: rtl/sram_16byte_1r1w.sv
`default_nettype none
// ============================================================================
// Module   : sram_16byte_1r1w
// Brief    : 16x8 1R1W SRAM model, active-low selects, read-before-write.
// Revision : 1.0 - initial release
// ============================================================================
module sram_16byte_1r1w #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16
) (
    input  logic                  pclk,
    input  logic                  rst_n,
    input  logic                  csb0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] din0,
    input  logic                  csb1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    output logic [DATA_WIDTH-1:0] dout1
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [DATA_WIDTH-1:0] dout1_q;
    logic [DATA_WIDTH-1:0] dout1_d;

    // The read samples mem_q, so a same-address write lands after the read.
    always_comb begin
        mem_d = mem_q;
        if (!csb0) begin
            mem_d[addr0] = din0;
        end
    end

    always_comb begin
        dout1_d = dout1_q;
        if (!csb1) begin
            dout1_d = mem_q[addr1];
        end
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            dout1_q <= '0;
        end else begin
            mem_q   <= mem_d;
            dout1_q <= dout1_d;
        end
    end

    assign dout1 = dout1_q;

endmodule
`default_nettype wire

// File: tb/tb_sram_16byte_1r1w.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_16byte_1r1w
// Brief    : Directed self-checking bench for sram_16byte_1r1w.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_sram_16byte_1r1w;

    logic       pclk;
    logic       rst_n;
    logic       csb0;
    logic [3:0] addr0;
    logic [7:0] din0;
    logic       csb1;
    logic [3:0] addr1;
    logic [7:0] dout1;

    int checks;
    int failures;

    sram_16byte_1r1w dut (
        .pclk  (pclk),
        .rst_n (rst_n),
        .csb0  (csb0),
        .addr0 (addr0),
        .din0  (din0),
        .csb1  (csb1),
        .addr1 (addr1),
        .dout1 (dout1)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    // Advance one rising edge; inputs change and outputs are sampled 1ns later.
    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        csb0  = 1'b1;
        csb1  = 1'b1;
        addr0 = 4'd0;
        addr1 = 4'd0;
        din0  = 8'h00;
        tick();
        checks++;
        if (dout1 !== 8'h00) begin
            failures++;
            $display("FAIL reset_dout actual=%h expected=00", dout1);
        end
        rst_n = 1'b1;
        tick();
        csb1  = 1'b0;
        addr1 = 4'd5;
        tick();
        checks++;
        if (dout1 !== 8'h00) begin
            failures++;
            $display("FAIL reset_read5 actual=%h expected=00", dout1);
        end
        csb1 = 1'b1;
        tick();
        checks++;
        if (dout1 !== 8'h00) begin
            failures++;
            $display("FAIL reset_hold actual=%h expected=00", dout1);
        end
    endtask

    task automatic test_write_read();
        csb0  = 1'b0;
        addr0 = 4'd3;
        din0  = 8'hA5;
        tick();
        csb0  = 1'b1;
        csb1  = 1'b0;
        addr1 = 4'd3;
        #2;
        checks++;
        if (dout1 !== 8'h00) begin
            failures++;
            $display("FAIL wr_no_comb_path actual=%h expected=00", dout1);
        end
        tick();
        checks++;
        if (dout1 !== 8'hA5) begin
            failures++;
            $display("FAIL wr_read3 actual=%h expected=a5", dout1);
        end
        csb1 = 1'b1;
    endtask

    task automatic test_sweep();
        for (int i = 0; i < 16; i++) begin
            csb0  = 1'b0;
            addr0 = 4'(i);
            din0  = 8'hFF - 8'(i);
            tick();
        end
        csb0 = 1'b1;
        for (int i = 0; i < 16; i++) begin
            csb1  = 1'b0;
            addr1 = 4'(i);
            tick();
            checks++;
            if (dout1 !== 8'hFF - 8'(i)) begin
                failures++;
                $display("FAIL sweep_read addr=%0d actual=%h expected=%h",
                         i, dout1, 8'hFF - 8'(i));
            end
        end
        csb1 = 1'b1;
    endtask

    task automatic test_collision();
        csb0  = 1'b0;
        addr0 = 4'd7;
        din0  = 8'h11;
        tick();
        din0  = 8'h22;
        csb1  = 1'b0;
        addr1 = 4'd7;
        tick();
        checks++;
        if (dout1 !== 8'h11) begin
            failures++;
            $display("FAIL collision_old actual=%h expected=11", dout1);
        end
        csb0 = 1'b1;
        tick();
        checks++;
        if (dout1 !== 8'h22) begin
            failures++;
            $display("FAIL collision_new actual=%h expected=22", dout1);
        end
        csb1 = 1'b1;
    endtask

    task automatic test_hold();
        csb0  = 1'b0;
        addr0 = 4'd2;
        din0  = 8'h5A;
        tick();
        csb0  = 1'b1;
        csb1  = 1'b0;
        addr1 = 4'd2;
        tick();
        checks++;
        if (dout1 !== 8'h5A) begin
            failures++;
            $display("FAIL hold_read2 actual=%h expected=5a", dout1);
        end
        csb1 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            addr1 = (k % 2 == 0) ? 4'd3 : 4'd15;
            tick();
            checks++;
            if (dout1 !== 8'h5A) begin
                failures++;
                $display("FAIL hold_idle cycle=%0d actual=%h expected=5a", k, dout1);
            end
        end
    endtask

    task automatic test_back_to_back();
        csb0  = 1'b0;
        addr0 = 4'd9;
        din0  = 8'h3C;
        csb1  = 1'b0;
        addr1 = 4'd2;
        tick();
        checks++;
        if (dout1 !== 8'h5A) begin
            failures++;
            $display("FAIL b2b_read2 actual=%h expected=5a", dout1);
        end
        csb0  = 1'b1;
        addr1 = 4'd9;
        tick();
        checks++;
        if (dout1 !== 8'h3C) begin
            failures++;
            $display("FAIL b2b_read9 actual=%h expected=3c", dout1);
        end
        addr1 = 4'd0;
        tick();
        checks++;
        if (dout1 !== 8'hFF) begin
            failures++;
            $display("FAIL b2b_read0 actual=%h expected=ff", dout1);
        end
        csb1 = 1'b1;
    endtask

    task automatic test_async_reset();
        logic [3:0] addrs [4];
        addrs[0] = 4'd2;
        addrs[1] = 4'd3;
        addrs[2] = 4'd7;
        addrs[3] = 4'd9;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (dout1 !== 8'h00) begin
            failures++;
            $display("FAIL async_reset_dout actual=%h expected=00", dout1);
        end
        #1;
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            csb1  = 1'b0;
            addr1 = addrs[i];
            tick();
            checks++;
            if (dout1 !== 8'h00) begin
                failures++;
                $display("FAIL async_reset_mem addr=%0d actual=%h expected=00",
                         addrs[i], dout1);
            end
        end
        csb1 = 1'b1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_write_read();
        test_sweep();
        test_collision();
        test_hold();
        test_back_to_back();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
